// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit 7-segment scan controller with inter-digit blanking and leading-zero suppression
module disp_scan_ctrl #(
  parameter int DIV_WIDTH = 17,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  en,
  input  logic        lz_en,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [1:0]  ctrl,
  output logic [3:0]  AN
);
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] blank_cnt;
  logic [3:0]           lz;
  logic                 tick;
  assign tick = &cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      ctrl         <= 2'd0;
      {D, C, B, A} <= 16'h0;
      blank_cnt    <= DIV_WIDTH'(BLANK_CYC);
    end else begin
      cnt       <= cnt + 1'b1;
      ctrl      <= tick ? ctrl + 2'd1 : ctrl;
      blank_cnt <= tick ? DIV_WIDTH'(BLANK_CYC) : (blank_cnt != 0 ? blank_cnt - 1'b1 : blank_cnt);
      if (load) {D, C, B, A} <= data_in;
    end
  end
  // Only the scanned digit can be driven low, so at most one AN bit is ever active.
  always_comb begin
    lz = lz_en ? {D != 4'h0, (C | D) != 4'h0, (B | C | D) != 4'h0, 1'b1} : 4'hF;
    AN = 4'hF;
    if (blank_cnt == 0) AN[ctrl] = ~(en[ctrl] & lz[ctrl]);
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: table vectors, corner sequences and random stimulus against a cycle-count model
module tb_disp_scan_ctrl;
  localparam int DW = 3;
  localparam int BC = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  en = 4'hF;
  logic        lz_en = 1'b0;
  logic [3:0]  A, B, C, D, AN;
  logic [1:0]  ctrl;
  int          compared = 0;
  int          mismatched = 0;
  int          k = 0;
  logic [15:0] mdata = 16'h0;
  typedef struct {
    logic        ld;
    logic [15:0] din;
    logic [3:0]  en;
    logic        lz;
    logic [1:0]  ctrl;
    logic [3:0]  an;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[12];

  disp_scan_ctrl #(.DIV_WIDTH(DW), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en), .lz_en(lz_en),
    .A(A), .B(B), .C(C), .D(D), .ctrl(ctrl), .AN(AN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Edge k since reset: slot index k/8, position k%8; blanking covers the first BC positions of every slot.
  function automatic logic [3:0] model_an();
    int  c;
    logic lit;
    c = (k >> DW) % 4;
    if ((k % (1 << DW)) < BC) return 4'hF;
    lit = en[c] && (!lz_en || c == 0 || (mdata >> (4 * c)) != 16'h0);
    return lit ? ~(4'b0001 << c) : 4'hF;
  endfunction

  task automatic check_model();
    chk("ctrl", 16'(ctrl), 16'((k >> DW) % 4));
    chk("an", 16'(AN), 16'(model_an()));
    chk("data", {D, C, B, A}, mdata);
    chk("an_onehot", 16'($countones(~AN) <= 1), 16'd1);
  endtask

  task automatic cycle(input logic ld, input logic [15:0] din, input logic [3:0] e, input logic lz);
    load = ld; data_in = din; en = e; lz_en = lz;
    @(posedge clk);
    k++;
    if (ld) mdata = din;
    @(negedge clk);
    check_model();
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].ld, tbl[i].din, tbl[i].en, tbl[i].lz);
      chk($sformatf("tbl%0d_ctrl", i), 16'(ctrl), 16'(tbl[i].ctrl));
      chk($sformatf("tbl%0d_an", i), 16'(AN), 16'(tbl[i].an));
      chk($sformatf("tbl%0d_data", i), {D, C, B, A}, tbl[i].data);
    end
  endtask

  task automatic seen_low(input logic [15:0] din, input logic [3:0] e, input logic lz,
                          input logic [3:0] exp, input string name);
    logic [3:0] seen;
    seen = 4'h0;
    cycle(1'b1, din, e, lz);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, din, e, lz);
      seen |= ~AN;
    end
    chk(name, 16'(seen), 16'(exp));
  endtask

  initial begin
    logic [1:0] pc;
    int         n;
    tbl[0]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1111, 16'h0};
    tbl[1]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[2]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[3]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[4]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[5]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[6]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd0, 4'b1110, 16'h0};
    tbl[7]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd1, 4'b1111, 16'h0};
    tbl[8]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd1, 4'b1111, 16'h0};
    tbl[9]  = '{1'b0, 16'h0,    4'hF, 1'b0, 2'd1, 4'b1101, 16'h0};
    tbl[10] = '{1'b1, 16'h8421, 4'hF, 1'b0, 2'd1, 4'b1101, 16'h8421};
    tbl[11] = '{1'b0, 16'h0,    4'hF, 1'b1, 2'd1, 4'b1101, 16'h8421};
    @(negedge clk);
    chk("rst_ctrl", 16'(ctrl), 16'd0);
    chk("rst_an", 16'(AN), 16'hF);
    chk("rst_data", {D, C, B, A}, 16'h0);
    rst = 1'b0;
    k = 0; mdata = 16'h0;
    chk("post_rst_an", 16'(AN), 16'hF);
    run_table();
    for (int i = 0; i < 32; i++) cycle(1'b0, 16'h0, 4'hF, 1'b0);
    n = 0;
    while (k % 8 != 7 && n < 8) begin cycle(1'b0, 16'h0, 4'hF, 1'b0); n++; end
    pc = ctrl;
    cycle(1'b1, 16'h1234, 4'hF, 1'b0);
    chk("tick_load_data", {D, C, B, A}, 16'h1234);
    chk("tick_load_ctrl", 16'(ctrl), 16'(pc + 2'd1));
    seen_low(16'h0042, 4'hF, 1'b1, 4'b0011, "lz_0042");
    seen_low(16'h0000, 4'hF, 1'b1, 4'b0001, "lz_0000");
    seen_low(16'h8421, 4'b0101, 1'b0, 4'b0101, "en_0101");
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0,
            $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)),
            4'($urandom), 1'($urandom));
    cycle(1'b1, 16'hBEEF, 4'hF, 1'b0);
    n = 0;
    while (!((k >> DW) % 4 == 2 && k % 8 == 4) && n < 64) begin cycle(1'b0, 16'h0, 4'hF, 1'b0); n++; end
    chk("pre_rst_ctrl", 16'(ctrl), 16'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 16'(ctrl), 16'd0);
    chk("async_rst_data", {D, C, B, A}, 16'h0);
    chk("async_rst_an", 16'(AN), 16'hF);
    #1 rst = 1'b0;
    k = 0; mdata = 16'h0;
    run_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
